fp_align_prep: RTL and testbench

Operand-preparation stage of the single-precision floating-point adder, placed directly upstream of the 28-bit alignment right-shifter. It accepts two IEEE-754 binary32 operands over a valid/ready handshake and unpacks them. It orders them by magnitude and computes the saturated 5-bit shift amount that drives the shifter, plus the sticky bit for any mantissa bits the shifter discards. It is a two-stage elastic pipeline with back-pressure.

---
 rtl/fp_align_prep.sv | 178 +++++++++++++++++
 tb/tb_fp_align_prep.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_prep.sv
// fp_align_prep: operand-preparation stage of the binary32 adder.
// Unpacks two operands, orders them by magnitude, and produces the saturated
// alignment shift and discarded-bit sticky for the 28-bit right shifter.
// Two-stage elastic pipeline (S1: unpack/order, S2: shift/sticky) with
// back-pressure driven combinationally from out_ready.
module fp_align_prep #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int SHFT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     a,
    input  logic [EXP_W+FRAC_W:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      big_sign,
    output logic                      eff_sub,
    output logic [EXP_W-1:0]          exp_big,
    output logic [FRAC_W+4:0]         mant_big,
    output logic [FRAC_W+4:0]         mant_small,
    output logic [SHFT_W-1:0]         shft,
    output logic                      sticky,
    output logic                      is_nan,
    output logic                      is_inf
);

    localparam int W        = 1 + EXP_W + FRAC_W;
    localparam int MANT_W   = FRAC_W + 5;
    localparam int SHFT_MAX = (1 << SHFT_W) - 1;

    // One operand after unpacking into shifter format.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  e;     // effective exponent (denormal/zero -> 1)
        logic [MANT_W-1:0] m;     // {carry, hidden, fraction, g/r/s}
        logic              nan;
        logic              inf;
    } op_t;

    // Unpack a binary32 word: denormals share exponent 1 with no hidden bit.
    function automatic op_t unpack(input logic [W-1:0] x);
        logic [EXP_W-1:0]  exp_f;
        logic [FRAC_W-1:0] frac_f;
        logic              hidden;
        op_t               u;
        exp_f  = x[W-2 -: EXP_W];
        frac_f = x[FRAC_W-1:0];
        hidden = (exp_f != '0);
        u.sign = x[W-1];
        u.e    = hidden ? exp_f : EXP_W'(1);
        u.m    = {1'b0, hidden, frac_f, 3'b000};
        u.nan  = (&exp_f) & (|frac_f);
        u.inf  = (&exp_f) & ~(|frac_f);
        return u;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic v1, v2;
    logic adv1, adv2;

    assign adv2      = ~v2 | out_ready;
    assign adv1      = ~v1 | adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // ------------------------------------------------------------------
    // Stage 1: unpack, magnitude order, special-value classification
    // ------------------------------------------------------------------
    op_t               op_a, op_b;
    logic              b_big;
    logic              big_sign_n, eff_sub_n, nan_n, inf_n;
    logic [EXP_W-1:0]  e_big_n, e_small_n;
    logic [MANT_W-1:0] m_big_n, m_small_n;

    // Order the operands by |value|; on equal magnitude A stays the big one.
    always_comb begin
        op_a       = unpack(a);
        op_b       = unpack(b);
        // Sign bit excluded: {exp,frac} compares as an unsigned magnitude.
        b_big      = (b[W-2:0] > a[W-2:0]);
        big_sign_n = b_big ? op_b.sign : op_a.sign;
        e_big_n    = b_big ? op_b.e    : op_a.e;
        e_small_n  = b_big ? op_a.e    : op_b.e;
        m_big_n    = b_big ? op_b.m    : op_a.m;
        m_small_n  = b_big ? op_a.m    : op_b.m;
        eff_sub_n  = op_a.sign ^ op_b.sign;
        // inf - inf is invalid and yields NaN, as does any NaN input.
        nan_n      = op_a.nan | op_b.nan | (op_a.inf & op_b.inf & eff_sub_n);
        inf_n      = (op_a.inf | op_b.inf) & ~nan_n;
    end

    logic              s1_big_sign, s1_eff_sub, s1_nan, s1_inf;
    logic [EXP_W-1:0]  s1_e_big, s1_e_small;
    logic [MANT_W-1:0] s1_m_big, s1_m_small;

    // Pipeline valid bits: reset empties both stages, discarding in-flight pairs.
    // NOTE: sequential state uses <= so every flop samples pre-edge values
    // regardless of statement order within or across always_ff blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
        end
    end

    // S1 payload register; loads only when a pair is actually accepted.
    // NOTE: payload flops have no reset -- v1 alone says whether they mean
    // anything, so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_big_sign <= big_sign_n;
            s1_eff_sub  <= eff_sub_n;
            s1_e_big    <= e_big_n;
            s1_e_small  <= e_small_n;
            s1_m_big    <= m_big_n;
            s1_m_small  <= m_small_n;
            s1_nan      <= nan_n;
            s1_inf      <= inf_n;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: exponent difference, saturated shift, sticky
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]  d;
    logic [SHFT_W-1:0] shft_n;
    logic [MANT_W-1:0] keep;
    logic              sticky_n;

    // d is never negative because S1 already put the larger exponent on top.
    // The sticky mask selects bit k when k < d, which also caps at MANT_W.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop, so no path can leave it unassigned and infer a latch.
        keep     = '0;
        d        = s1_e_big - s1_e_small;
        shft_n   = (d > EXP_W'(SHFT_MAX)) ? SHFT_W'(SHFT_MAX) : d[SHFT_W-1:0];
        for (int k = 0; k < MANT_W; k++) begin
            keep[k] = (EXP_W'(k) < d);
        end
        sticky_n = |(s1_m_small & keep);
    end

    // S2 output register: holds while stalled; cleared on reset so the
    // outputs read zero until the first result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            big_sign   <= 1'b0;
            eff_sub    <= 1'b0;
            exp_big    <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            shft       <= '0;
            sticky     <= 1'b0;
            is_nan     <= 1'b0;
            is_inf     <= 1'b0;
        end else if (adv2 && v1) begin
            big_sign   <= s1_big_sign;
            eff_sub    <= s1_eff_sub;
            exp_big    <= s1_e_big;
            mant_big   <= s1_m_big;
            mant_small <= s1_m_small;
            shft       <= shft_n;
            sticky     <= sticky_n;
            is_nan     <= s1_nan;
            is_inf     <= s1_inf;
        end
    end

endmodule

// File: tb/tb_fp_align_prep.sv
// Self-checking bench for fp_align_prep: table of operand pairs with
// hand-derived expected outputs, a scoreboard queue filled on acceptance and
// drained on output handshake, plus stall, reset and latency sequences.
module tb_fp_align_prep;

    typedef struct packed {
        logic        big_sign;
        logic        eff_sub;
        logic [7:0]  exp_big;
        logic [27:0] mant_big;
        logic [27:0] mant_small;
        logic [4:0]  shft;
        logic        sticky;
        logic        is_nan;
        logic        is_inf;
    } out_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        out_t        e;
    } vec_t;

    localparam int NVEC = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        big_sign, eff_sub, sticky, is_nan, is_inf;
    logic [7:0]  exp_big;
    logic [27:0] mant_big, mant_small;
    logic [4:0]  shft;

    vec_t vecs[NVEC];
    out_t sb[$];
    int   cur_idx = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    bit   prev_stall = 1'b0;
    out_t snap;

    always #5 clk = ~clk;

    fp_align_prep dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .big_sign   (big_sign),
        .eff_sub    (eff_sub),
        .exp_big    (exp_big),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .shft       (shft),
        .sticky     (sticky),
        .is_nan     (is_nan),
        .is_inf     (is_inf)
    );

    function automatic out_t cur_out();
        out_t o;
        o.big_sign   = big_sign;
        o.eff_sub    = eff_sub;
        o.exp_big    = exp_big;
        o.mant_big   = mant_big;
        o.mant_small = mant_small;
        o.shft       = shft;
        o.sticky     = sticky;
        o.is_nan     = is_nan;
        o.is_inf     = is_inf;
        return o;
    endfunction

    function automatic vec_t mk(input logic [31:0] av, input logic [31:0] bv,
                                input logic bs, input logic es, input logic [7:0] eb,
                                input logic [27:0] mb, input logic [27:0] ms,
                                input logic [4:0] sh, input logic st,
                                input logic nn, input logic nf);
        vec_t v;
        v.a = av;
        v.b = bv;
        v.e = '{big_sign: bs, eff_sub: es, exp_big: eb, mant_big: mb,
                mant_small: ms, shft: sh, sticky: st, is_nan: nn, is_inf: nf};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input out_t act, input out_t exp);
        check({tag, ".big_sign"},   32'(act.big_sign),   32'(exp.big_sign));
        check({tag, ".eff_sub"},    32'(act.eff_sub),    32'(exp.eff_sub));
        check({tag, ".exp_big"},    32'(act.exp_big),    32'(exp.exp_big));
        check({tag, ".mant_big"},   32'(act.mant_big),   32'(exp.mant_big));
        check({tag, ".mant_small"}, 32'(act.mant_small), 32'(exp.mant_small));
        check({tag, ".shft"},       32'(act.shft),       32'(exp.shft));
        check({tag, ".sticky"},     32'(act.sticky),     32'(exp.sticky));
        check({tag, ".is_nan"},     32'(act.is_nan),     32'(exp.is_nan));
        check({tag, ".is_inf"},     32'(act.is_inf),     32'(exp.is_inf));
    endtask

    // Scoreboard monitor: mid-cycle, decide what the coming edge transfers.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check_out("stall_hold", cur_out(), snap);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    check_out("result", cur_out(), sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(vecs[cur_idx].e);
            prev_stall = out_valid && !out_ready;
            snap       = cur_out();
        end
    end

    // Present one pair and hold it until the DUT accepts it.
    task automatic send(input int idx);
        int waited = 0;
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        cur_idx  = idx;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              a             b             bs    es    exp    mant_big     mant_small   sh  st nan inf
        vecs[0]  = mk(32'h40000000, 32'h3F800000, 1'b0, 1'b0, 8'h80, 28'h4000000, 28'h4000000, 5'd1,  1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(32'h3F800000, 32'hC0400000, 1'b1, 1'b1, 8'h80, 28'h6000000, 28'h4000000, 5'd1,  1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(32'h4B800000, 32'h3F800001, 1'b0, 1'b0, 8'h97, 28'h4000000, 28'h4000008, 5'd24, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(32'h4B800000, 32'h3F800000, 1'b0, 1'b0, 8'h97, 28'h4000000, 28'h4000000, 5'd24, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(32'h7F000000, 32'h00800000, 1'b0, 1'b0, 8'hFE, 28'h4000000, 28'h4000000, 5'd31, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 8'hFF, 28'h4000000, 28'h4000000, 5'd0,  1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 28'h4000000, 28'h4000000, 5'd31, 1'b1, 1'b0, 1'b1);
        vecs[7]  = mk(32'h00000000, 32'h80000000, 1'b0, 1'b1, 8'h01, 28'h0000000, 28'h0000000, 5'd0,  1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(32'h00000001, 32'h00800000, 1'b0, 1'b0, 8'h01, 28'h4000000, 28'h0000008, 5'd0,  1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 28'h6000000, 28'h4000000, 5'd31, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(32'h4C800000, 32'h3F800000, 1'b0, 1'b0, 8'h99, 28'h4000000, 28'h4000000, 5'd26, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(32'h4D000000, 32'h3F800000, 1'b0, 1'b0, 8'h9A, 28'h4000000, 28'h4000000, 5'd27, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(32'h4F800000, 32'h3F800000, 1'b0, 1'b0, 8'h9F, 28'h4000000, 28'h4000000, 5'd31, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(32'hBF800000, 32'h40000000, 1'b0, 1'b1, 8'h80, 28'h4000000, 28'h4000000, 5'd1,  1'b0, 1'b0, 1'b0);
        vecs[14] = mk(32'h3F800000, 32'hBF800000, 1'b0, 1'b1, 8'h7F, 28'h4000000, 28'h4000000, 5'd0,  1'b0, 1'b0, 1'b0);
        vecs[15] = mk(32'h3F800000, 32'h3F800001, 1'b0, 1'b0, 8'h7F, 28'h4000008, 28'h4000000, 5'd0,  1'b0, 1'b0, 1'b0);
        vecs[16] = mk(32'hFF800000, 32'h7F800001, 1'b0, 1'b1, 8'hFF, 28'h4000008, 28'h4000000, 5'd0,  1'b0, 1'b1, 1'b0);

        // Reset with a pair presented: it must be ignored.
        a        = vecs[0].a;
        b        = vecs[0].b;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check_out("rst_state", cur_out(), '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_valid_ignored", 32'(out_valid), 32'd0);

        // Table pass, back-to-back with out_ready held high.
        for (int i = 0; i < NVEC; i++) send(i);
        drain();

        // Table pass again under random back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < NVEC; i++) send(i);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Full stall: two accepted, third presented and refused for 5 cycles.
        out_ready = 1'b0;
        send(0);
        send(1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        a        = vecs[2].a;
        b        = vecs[2].b;
        cur_idx  = 2;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready_hold", 32'(in_ready), 32'd0);
            check_out("stall_seq", cur_out(), vecs[0].e);
        end
        out_ready = 1'b1;
        send(2);
        send(3);
        drain();

        // Reset with two pairs in flight.
        out_ready = 1'b0;
        send(4);
        send(5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check_out("rst2_state", cur_out(), '0);

        // Fresh pair after reset: out_valid rises one edge after S1 loads.
        out_ready = 1'b1;
        send(9);
        check("lat_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_s2_valid", 32'(out_valid), 32'd1);
        drain();

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
